// File: rtl/alu_muldiv.sv
// alu_muldiv: single-issue integer execution unit. It covers the base ALU
// operations, a multiplier with a fixed configurable latency, and a restoring
// divider that produces one quotient bit per cycle. The unit holds at most one
// operation at a time.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready  request handshake; op, a, b, tag form the request
//   flush                drops whatever is in flight or waiting in DONE
//   out_valid/out_ready  result handshake; result and out_tag are held
//                        stable while out_valid is high
module alu_muldiv #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = 7;
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_MULH   = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_MULHU  = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd15;
    localparam logic [4:0] OP_DIVU   = 5'd16;
    localparam logic [4:0] OP_REM    = 5'd17;
    localparam logic [4:0] OP_REMU   = 5'd18;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_r, state_n_s;
    logic [XLEN-1:0]    result_r, result_n_s;
    logic [TAG_W-1:0]   tag_r, tag_n_s;
    logic [CNT_W-1:0]   cnt_r, cnt_n_s;
    logic [XLEN-1:0]    prod_r, prod_n_s;
    logic [XLEN-1:0]    rem_r, rem_n_s;
    logic [XLEN-1:0]    quo_r, quo_n_s;
    logic [XLEN-1:0]    dvs_r, dvs_n_s;
    logic               neg_r, neg_n_s;
    logic               sel_rem_r, sel_rem_n_s;

    logic               accept_s;
    logic [SHW-1:0]     shamt_s;
    logic [XLEN-1:0]    base_res_s;
    logic               a_sx_s, b_sx_s;
    logic [2*XLEN-1:0]  mul_a_s, mul_b_s, mul_p_s;
    logic [XLEN-1:0]    mul_res_s;
    logic               div_signed_s, div_is_rem_s, div_ovf_s;
    logic [XLEN-1:0]    a_mag_s, b_mag_s;
    logic [XLEN:0]      shift_s, diff_s;
    logic [XLEN-1:0]    step_rem_s, step_quo_s, div_sel_s, div_final_s;

    // flush and reset both block acceptance; DONE can hand over back-to-back
    assign in_ready  = rst_n & ~flush &
                       ((state_r == IDLE) | ((state_r == DONE) & out_ready));
    assign accept_s  = in_valid & in_ready;
    assign out_valid = (state_r == DONE);
    assign result    = result_r;
    assign out_tag   = tag_r;
    assign shamt_s   = b[SHW-1:0];

    // Single-cycle ALU operations; unused codes return zero
    always_comb begin
        base_res_s = ZERO;
        case (op)
            OP_ADD:   base_res_s = a + b;
            OP_SUB:   base_res_s = a - b;
            OP_SLL:   base_res_s = a << shamt_s;
            OP_SLT:   base_res_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  base_res_s = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:   base_res_s = a ^ b;
            OP_SRL:   base_res_s = a >> shamt_s;
            OP_SRA:   base_res_s = $unsigned($signed(a) >>> shamt_s);
            OP_OR:    base_res_s = a | b;
            OP_AND:   base_res_s = a & b;
            OP_PASSB: base_res_s = b;
            default:  base_res_s = ZERO;
        endcase
    end

    // Multiplier: extending each operand to 2*XLEN with the chosen sign bit
    // makes one unsigned product exact for all signedness combinations
    always_comb begin
        a_sx_s    = (op != OP_MULHU) & a[XLEN-1];
        b_sx_s    = ((op == OP_MUL) | (op == OP_MULH)) & b[XLEN-1];
        mul_a_s   = {{XLEN{a_sx_s}}, a};
        mul_b_s   = {{XLEN{b_sx_s}}, b};
        mul_p_s   = mul_a_s * mul_b_s;
        mul_res_s = (op == OP_MUL) ? mul_p_s[XLEN-1:0] : mul_p_s[2*XLEN-1:XLEN];
    end

    // Divider operand preparation and one restoring step on the held state
    always_comb begin
        div_signed_s = (op == OP_DIV) | (op == OP_REM);
        div_is_rem_s = (op == OP_REM) | (op == OP_REMU);
        div_ovf_s    = div_signed_s & (a == MIN_NEG) & (b == ONES);
        a_mag_s      = (div_signed_s & a[XLEN-1]) ? (ZERO - a) : a;
        b_mag_s      = (div_signed_s & b[XLEN-1]) ? (ZERO - b) : b;
        shift_s      = {rem_r, quo_r[XLEN-1]};
        diff_s       = shift_s - {1'b0, dvs_r};
        if (diff_s[XLEN]) begin
            step_rem_s = shift_s[XLEN-1:0];
            step_quo_s = {quo_r[XLEN-2:0], 1'b0};
        end else begin
            step_rem_s = diff_s[XLEN-1:0];
            step_quo_s = {quo_r[XLEN-2:0], 1'b1};
        end
        div_sel_s   = sel_rem_r ? step_rem_s : step_quo_s;
        div_final_s = neg_r ? (ZERO - div_sel_s) : div_sel_s;
    end

    // Next-state and datapath-load decisions for the control FSM
    always_comb begin
        state_n_s   = state_r;
        result_n_s  = result_r;
        tag_n_s     = tag_r;
        cnt_n_s     = cnt_r;
        prod_n_s    = prod_r;
        rem_n_s     = rem_r;
        quo_n_s     = quo_r;
        dvs_n_s     = dvs_r;
        neg_n_s     = neg_r;
        sel_rem_n_s = sel_rem_r;
        if (flush) begin
            state_n_s = IDLE;
        end else if (accept_s) begin
            tag_n_s = tag;
            case (op)
                OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
                    if (MUL_LAT == 1) begin
                        result_n_s = mul_res_s;
                        state_n_s  = DONE;
                    end else begin
                        prod_n_s  = mul_res_s;
                        cnt_n_s   = CNT_W'(MUL_LAT - 2);
                        state_n_s = MUL;
                    end
                end
                OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                    sel_rem_n_s = div_is_rem_s;
                    if (b == ZERO) begin
                        result_n_s = div_is_rem_s ? a : ONES;
                        state_n_s  = DONE;
                    end else if (div_ovf_s) begin
                        result_n_s = div_is_rem_s ? ZERO : a;
                        state_n_s  = DONE;
                    end else begin
                        rem_n_s   = ZERO;
                        quo_n_s   = a_mag_s;
                        dvs_n_s   = b_mag_s;
                        neg_n_s   = div_signed_s &
                                    (div_is_rem_s ? a[XLEN-1] : (a[XLEN-1] ^ b[XLEN-1]));
                        cnt_n_s   = CNT_W'(XLEN - 1);
                        state_n_s = DIV;
                    end
                end
                default: begin
                    result_n_s = base_res_s;
                    state_n_s  = DONE;
                end
            endcase
        end else begin
            case (state_r)
                IDLE: state_n_s = IDLE;
                MUL: begin
                    if (cnt_r == CNT_ZERO) begin
                        result_n_s = prod_r;
                        state_n_s  = DONE;
                    end else begin
                        cnt_n_s = cnt_r - CNT_ONE;
                    end
                end
                DIV: begin
                    rem_n_s = step_rem_s;
                    quo_n_s = step_quo_s;
                    if (cnt_r == CNT_ZERO) begin
                        result_n_s = div_final_s;
                        state_n_s  = DONE;
                    end else begin
                        cnt_n_s = cnt_r - CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = DONE;
                    end
                end
                default: state_n_s = IDLE;
            endcase
        end
    end

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            result_r  <= ZERO;
            tag_r     <= {TAG_W{1'b0}};
            cnt_r     <= CNT_ZERO;
            prod_r    <= ZERO;
            rem_r     <= ZERO;
            quo_r     <= ZERO;
            dvs_r     <= ZERO;
            neg_r     <= 1'b0;
            sel_rem_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            result_r  <= result_n_s;
            tag_r     <= tag_n_s;
            cnt_r     <= cnt_n_s;
            prod_r    <= prod_n_s;
            rem_r     <= rem_n_s;
            quo_r     <= quo_n_s;
            dvs_r     <= dvs_n_s;
            neg_r     <= neg_n_s;
            sel_rem_r <= sel_rem_n_s;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv (XLEN=32, MUL_LAT=2). Requests are pushed to a
// scoreboard with their expected result, tag and latency; a monitor on the
// falling edge compares every cycle out_valid is high and pops on handshake.
module tb_alu_muldiv;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       op = 5'd0;
    logic [XLEN-1:0]  a = 32'd0;
    logic [XLEN-1:0]  b = 32'd0;
    logic [TAG_W-1:0] tag = 5'd0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;

    alu_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag(tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tg;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    bit   head_seen = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        longint sx, sy, ux, uy;
        int si, yi;
        logic ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'd0, x});
        uy  = longint'({32'd0, y});
        si  = $signed(x);
        yi  = $signed(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return x << y[4:0];
            5'd3:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd4:  return (x < y) ? 32'd1 : 32'd0;
            5'd5:  return x ^ y;
            5'd6:  return x >> y[4:0];
            5'd7:  return $signed(x) >>> y[4:0];
            5'd8:  return x | y;
            5'd9:  return x & y;
            5'd10: return y;
            5'd11: begin p = sx * sy; return p[31:0]; end
            5'd12: begin p = sx * sy; return p[63:32]; end
            5'd13: begin p = sx * uy; return p[63:32]; end
            5'd14: begin p = ux * uy; return p[63:32]; end
            5'd15: return (y == 32'd0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(si / yi));
            5'd16: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            5'd17: return (y == 32'd0) ? x : (ovf ? 32'd0 : 32'(si % yi));
            5'd18: return (y == 32'd0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o >= 5'd11 && o <= 5'd14) return MUL_LAT;
        if (o >= 5'd15 && o <= 5'd18) begin
            if (y == 32'd0) return 1;
            if ((o == 5'd15 || o == 5'd17) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
        return 1;
    endfunction

    // Result monitor: compare the head entry every cycle it is presented
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check_value("spurious_valid", out_valid, 1'b0);
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    check_value("latency", cyc - sb[0].acc, sb[0].lat);
                end
                check_value("result", result, sb[0].res);
                check_value("out_tag", out_tag, sb[0].tg);
                if (out_ready) begin
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Present a request until accepted; returns the number of cycles waited
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, input logic [31:0] e, input int lat, output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        op = o; a = x; b = y; tag = t; in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{res: e, tg: t, acc: cyc, lat: lat});
                done = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!done) check_value("accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_m(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
        int w;
        issue(o, x, y, t, ref_res(o, x, y), ref_lat(o, x, y), w);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check_value("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int w;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_out_valid", out_valid, 1'b0);
        check_value("rst_result", result, 32'd0);
        check_value("rst_out_tag", out_tag, 5'd0);
        check_value("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // directed vectors with hand-computed expectations
        issue(5'd0,  32'h7FFF_FFFF, 32'd1, 5'd3, 32'h8000_0000, 1, w);
        issue(5'd12, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 2, w);
        issue(5'd14, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 2, w);
        issue(5'd11, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h0000_0000, 2, w);
        issue(5'd15, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33, w);
        issue(5'd17, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, w);
        issue(5'd16, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, w);
        issue(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1, w);
        issue(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, w);
        issue(5'd18, 32'd7, 32'd0, 5'd12, 32'd7, 1, w);
        issue(5'd7,  32'h8000_0010, 32'd36, 5'd13, 32'hF800_0001, 1, w);
        issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFF, 2, w);
        issue(5'd20, 32'd9, 32'd9, 5'd15, 32'd0, 1, w);
        drain();

        // random back-to-back traffic over every opcode
        for (int i = 0; i < 60; i++) begin
            issue_m(5'($urandom_range(0, 31)), pick(), pick(), 5'($urandom_range(0, 31)));
        end
        drain();

        // backpressure on a DONE result, then hand over back-to-back
        out_ready = 1'b0;
        issue(5'd2, 32'd1, 32'd35, 5'd17, 32'd8, 1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_value("hold_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd18, 32'hFF00_FF00, 1, w);
        check_value("b2b_accept_wait", w, 0);
        drain();

        // flush blocks acceptance even in IDLE
        flush = 1'b1; in_valid = 1'b1; op = 5'd0;
        @(negedge clk);
        check_value("flush_blocks_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;

        // flush a running DIVU at its tenth cycle
        issue(5'd16, 32'd100, 32'd7, 5'd19, 32'd14, 33, w);
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        head_seen = 1'b0;
        @(negedge clk);
        check_value("flush_div_valid", out_valid, 1'b0);
        check_value("ready_after_flush", in_ready, 1'b1);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;

        // flush a result waiting in DONE
        out_ready = 1'b0;
        issue(5'd0, 32'd40, 32'd2, 5'd20, 32'd42, 1, w);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        head_seen = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_value("flush_done_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // reset pulse in the middle of a multiply
        issue(5'd0, 32'd20, 32'd3, 5'd21, 32'd23, 1, w);
        drain();
        issue(5'd11, 32'd3, 32'd5, 5'd22, 32'd15, 2, w);
        rst_n = 1'b0;
        sb.delete();
        head_seen = 1'b0;
        #1;
        check_value("rst_mid_valid", out_valid, 1'b0);
        check_value("rst_mid_result", result, 32'd0);
        check_value("rst_mid_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_value("rel_in_ready", in_ready, 1'b1);
        check_value("rel_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        issue(5'd11, 32'd3, 32'd5, 5'd23, 32'd15, 2, w);
        issue_m(5'd17, 32'hFFFF_FF00, 32'd7, 5'd24);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand/result width; legal values 32 and 64.
REQ-002 Parameter MUL_LAT, default 2, SHALL set the multiply latency in cycles; legal range 1..4.
REQ-003 Parameter TAG_W, default 5, SHALL set the width of the destination tag passed through with each operation.
REQ-004 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RSTN  input  1  asynchronous, active-low reset.
REQ-006 IN_VALID  input  1  request present.
REQ-007 IN_READY  output  1  unit can accept a request this cycle.
REQ-008 OP  input  5  operation code, decoded per REQ-012.
REQ-009 A, B  input  XLEN each  operands; B is already immediate- or register-selected upstream.
REQ-010 TAG  input  TAG_W  destination tag, returned unchanged with the result.
REQ-011 FLUSH  input  1  abort the in-flight operation; OUT_VALID, OUT_READY, RESULT and OUT_TAG are the result-side ports.

Function
REQ-012 OP decode SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU; codes 19..31 SHALL yield result 0 with base-op latency.
REQ-013 Shift amounts SHALL use only B[log2(XLEN)-1:0]; SRA SHALL sign-fill; SLT/SLTU SHALL return 1 or 0, zero-extended.
REQ-014 ADD/SUB/MUL SHALL wrap modulo 2^XLEN; MULH/MULHSU/MULHU SHALL return the upper XLEN bits of the 2*XLEN product with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-015 DIV/DIVU SHALL truncate toward zero; REM/REMU SHALL take the sign of the dividend.
REQ-016 Divide by zero SHALL return quotient all-ones and remainder = A.
REQ-017 Signed overflow (A = most negative, B = -1) SHALL return quotient = A and remainder = 0.
REQ-018 The FSM SHALL have the states IDLE, MUL, DIV and DONE; the unit SHALL hold at most one operation at a time.
REQ-019 A request is accepted when IN_VALID && IN_READY at a rising edge.
REQ-020 IN_READY SHALL equal (state==IDLE) || (state==DONE && OUT_READY).
REQ-021 Base ops (0..10, 19..31) accepted in cycle N SHALL go straight to DONE, with OUT_VALID=1 in cycle N+1.
REQ-022 MUL ops SHALL pass through state MUL and assert OUT_VALID in cycle N+MUL_LAT.
REQ-023 DIV ops SHALL use a 1-bit-per-cycle restoring divider in state DIV and assert OUT_VALID in cycle N+XLEN+1.
REQ-024 Divide special cases (REQ-016, REQ-017) SHALL complete in cycle N+1.
REQ-025 In DONE, RESULT and OUT_TAG SHALL stay stable and OUT_VALID SHALL stay high until OUT_VALID && OUT_READY.
REQ-026 On that handshake the FSM SHALL go to IDLE, or directly start the next request when one is accepted in the same cycle (back-to-back, no bubble).
REQ-027 FLUSH=1 SHALL return the FSM to IDLE at the next edge, dropping any in-flight or DONE result, and OUT_VALID SHALL be 0 the following cycle.
REQ-028 FLUSH SHALL take priority over acceptance: IN_READY SHALL be 0 while FLUSH=1.
REQ-029 OUT_VALID SHALL never assert for a flushed operation.

Reset
REQ-030 While RSTN=0: state=IDLE, OUT_VALID=0, RESULT=0, OUT_TAG=0, divider and multiplier pipeline registers cleared, IN_READY=0.
REQ-031 RSTN asserted mid-operation SHALL discard that operation; after release the first edge SHALL show IN_READY=1 and no stale OUT_VALID.

Verification
REQ-032 ADD A=0x7FFFFFFF, B=1, TAG=3 -> RESULT=0x80000000, OUT_TAG=3, OUT_VALID one cycle after acceptance.
REQ-033 MULH A=0x80000000, B=0x80000000, MUL_LAT=2 -> RESULT=0x40000000 two cycles after acceptance; MULHU same operands -> 0x40000000; MUL -> 0.
REQ-034 DIV A=-7, B=2 -> 0xFFFFFFFD after 33 cycles; REM -> 0xFFFFFFFF; DIVU A=5, B=0 -> 0xFFFFFFFF; REM A=0x80000000, B=-1 -> 0, each of the last two after 1 cycle.
REQ-035 Hold OUT_READY=0 for 5 cycles on a DONE SLL (A=1, B=35) result -> RESULT=8 stable and IN_READY=0 throughout; then OUT_READY=1 with a new XOR request -> accepted that cycle, next result the following cycle.
REQ-036 Assert FLUSH at cycle 10 of a DIVU -> no OUT_VALID for it; IN_READY=1 the cycle after FLUSH deasserts.
REQ-037 Pulse RSTN low mid-MUL -> OUT_VALID=0 and RESULT=0 immediately; normal operation after release.
